mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 117 +++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of a simple pipelined datapath. It holds a word-wide
//   data memory that is indexed by the ALU byte address, and it latches the
//   write-back bundle once per cycle with no stall. It also resolves the
//   branch decision combinationally.
//
// Parameters
//   NB_ADDR      register-file address width
//   NB_DATA      datapath width (default 2**NB_ADDR)
//   NB_MEM_ADDR  data-memory word-address width (depth 2**NB_MEM_ADDR)
//
// Ports
//   i_clock, i_reset            clock (rising edge), async active-high reset
//   i_data_mem_wr_enb/_rd_enb   store / load request
//   i_is_branch_instruction,
//   i_alu_zero, i_branch_addr   branch resolution inputs
//   i_alu_result                byte address or ALU value
//   i_rf_rt_data                store data
//   i_rf_wr_enb, i_rf_wr_data_src, i_rf_wr_addr  write-back control
//   o_pc_src, o_branch_addr     branch taken / target (combinational)
//   o_*_ltchd                   registered write-back bundle
//   o_mem_misalign              sticky misaligned-access flag
//   i_dbg_mem_addr, o_dbg_mem_data  debug memory peek
//
// Build option
//   MEM_STAGE_DEBUG_PORT_EN  when defined, o_dbg_mem_data = mem[i_dbg_mem_addr]
//                            (combinational). When it is undefined, the output
//                            is tied to 0.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int NB_ADDR     = 5,
    parameter int NB_DATA     = 2**NB_ADDR,
    parameter int NB_MEM_ADDR = 6
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_data_mem_wr_enb,
    input  logic                   i_data_mem_rd_enb,
    input  logic                   i_is_branch_instruction,
    input  logic [NB_DATA-1:0]     i_alu_result,
    input  logic                   i_alu_zero,
    input  logic [NB_DATA-1:0]     i_branch_addr,
    input  logic [NB_DATA-1:0]     i_rf_rt_data,
    input  logic                   i_rf_wr_enb,
    input  logic                   i_rf_wr_data_src,
    input  logic [NB_ADDR-1:0]     i_rf_wr_addr,
    output logic                   o_pc_src,
    output logic [NB_DATA-1:0]     o_branch_addr,
    output logic [NB_DATA-1:0]     o_mem_rd_data_ltchd,
    output logic [NB_DATA-1:0]     o_alu_result_ltchd,
    output logic                   o_rf_wr_enb_ltchd,
    output logic                   o_rf_wr_data_src_ltchd,
    output logic [NB_ADDR-1:0]     o_rf_wr_addr_ltchd,
    output logic                   o_mem_misalign,
    input  logic [NB_MEM_ADDR-1:0] i_dbg_mem_addr,
    output logic [NB_DATA-1:0]     o_dbg_mem_data
);

    localparam int DEPTH = 2**NB_MEM_ADDR;

    logic [NB_DATA-1:0]     mem [DEPTH];
    logic [NB_MEM_ADDR-1:0] word_idx;
    logic                   misaligned;
    logic                   wr_ok;
    logic                   rd_ok;

    // The byte address is turned into a word index. Upper bits are dropped, so
    // the address wraps modulo the memory depth.
    assign word_idx   = i_alu_result[NB_MEM_ADDR+1:2];
    assign misaligned = (i_alu_result[1:0] != 2'b00) &&
                        (i_data_mem_wr_enb || i_data_mem_rd_enb);
    assign wr_ok      = i_data_mem_wr_enb && !misaligned;
    assign rd_ok      = i_data_mem_rd_enb && !misaligned;

    assign o_pc_src      = i_is_branch_instruction && i_alu_zero;
    assign o_branch_addr = i_branch_addr;

    // The storage is never cleared. Writes are blocked while reset is high, so
    // an access that overlaps a reset pulse is dropped.
    always_ff @(posedge i_clock) begin
        if (!i_reset && wr_ok) begin
            mem[word_idx] <= i_rf_rt_data;
        end
    end

    // The read samples mem before this edge's write commits, which gives
    // read-before-write behaviour when a load and a store hit the same word.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_mem_rd_data_ltchd    <= '0;
            o_alu_result_ltchd     <= '0;
            o_rf_wr_enb_ltchd      <= 1'b0;
            o_rf_wr_data_src_ltchd <= 1'b0;
            o_rf_wr_addr_ltchd     <= '0;
            o_mem_misalign         <= 1'b0;
        end else begin
            o_mem_rd_data_ltchd    <= rd_ok ? mem[word_idx] : '0;
            o_alu_result_ltchd     <= i_alu_result;
            o_rf_wr_enb_ltchd      <= i_rf_wr_enb;
            o_rf_wr_data_src_ltchd <= i_rf_wr_data_src;
            o_rf_wr_addr_ltchd     <= i_rf_wr_addr;
            if (misaligned) begin
                o_mem_misalign <= 1'b1;
            end
        end
    end

`ifdef MEM_STAGE_DEBUG_PORT_EN
    assign o_dbg_mem_data = mem[i_dbg_mem_addr];
`else
    logic unused_dbg_addr;
    assign unused_dbg_addr = ^i_dbg_mem_addr;
    assign o_dbg_mem_data  = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int NB_ADDR     = 5;
    localparam int NB_DATA     = 32;
    localparam int NB_MEM_ADDR = 6;
    localparam int DEPTH       = 64;

    logic                   i_clock;
    logic                   i_reset;
    logic                   i_data_mem_wr_enb;
    logic                   i_data_mem_rd_enb;
    logic                   i_is_branch_instruction;
    logic [NB_DATA-1:0]     i_alu_result;
    logic                   i_alu_zero;
    logic [NB_DATA-1:0]     i_branch_addr;
    logic [NB_DATA-1:0]     i_rf_rt_data;
    logic                   i_rf_wr_enb;
    logic                   i_rf_wr_data_src;
    logic [NB_ADDR-1:0]     i_rf_wr_addr;
    logic                   o_pc_src;
    logic [NB_DATA-1:0]     o_branch_addr;
    logic [NB_DATA-1:0]     o_mem_rd_data_ltchd;
    logic [NB_DATA-1:0]     o_alu_result_ltchd;
    logic                   o_rf_wr_enb_ltchd;
    logic                   o_rf_wr_data_src_ltchd;
    logic [NB_ADDR-1:0]     o_rf_wr_addr_ltchd;
    logic                   o_mem_misalign;
    logic [NB_MEM_ADDR-1:0] i_dbg_mem_addr;
    logic [NB_DATA-1:0]     o_dbg_mem_data;

    mem_stage #(
        .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_MEM_ADDR(NB_MEM_ADDR)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_data_mem_wr_enb(i_data_mem_wr_enb), .i_data_mem_rd_enb(i_data_mem_rd_enb),
        .i_is_branch_instruction(i_is_branch_instruction),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero),
        .i_branch_addr(i_branch_addr), .i_rf_rt_data(i_rf_rt_data),
        .i_rf_wr_enb(i_rf_wr_enb), .i_rf_wr_data_src(i_rf_wr_data_src),
        .i_rf_wr_addr(i_rf_wr_addr),
        .o_pc_src(o_pc_src), .o_branch_addr(o_branch_addr),
        .o_mem_rd_data_ltchd(o_mem_rd_data_ltchd),
        .o_alu_result_ltchd(o_alu_result_ltchd),
        .o_rf_wr_enb_ltchd(o_rf_wr_enb_ltchd),
        .o_rf_wr_data_src_ltchd(o_rf_wr_data_src_ltchd),
        .o_rf_wr_addr_ltchd(o_rf_wr_addr_ltchd),
        .o_mem_misalign(o_mem_misalign),
        .i_dbg_mem_addr(i_dbg_mem_addr), .o_dbg_mem_data(o_dbg_mem_data)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: word-addressed memory, validity bits, sticky flag.
    logic [NB_DATA-1:0] m_mem   [DEPTH];
    bit                 m_valid [DEPTH];
    bit                 m_mis;

    task automatic check(input string tag, input logic [NB_DATA-1:0] obs,
                         input logic [NB_DATA-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd"},   o_mem_rd_data_ltchd, '0);
        check({tag, "_alu"},  o_alu_result_ltchd, '0);
        check({tag, "_we"},   32'(o_rf_wr_enb_ltchd), 0);
        check({tag, "_src"},  32'(o_rf_wr_data_src_ltchd), 0);
        check({tag, "_addr"}, 32'(o_rf_wr_addr_ltchd), 0);
        check({tag, "_mis"},  32'(o_mem_misalign), 0);
    endtask

    // Runs one instruction through the stage. The branch and debug outputs
    // are checked before the edge. The latched outputs are checked 1 time unit
    // after the edge.
    task automatic step(input bit wr, input bit rd, input bit br, input bit zero,
                        input logic [NB_DATA-1:0] alu, input logic [NB_DATA-1:0] baddr,
                        input logic [NB_DATA-1:0] rt, input bit rfwe, input bit src,
                        input logic [NB_ADDR-1:0] waddr, input logic [NB_MEM_ADDR-1:0] dbg);
        int idx;
        bit mis;
        logic [NB_DATA-1:0] exp_rd;
        i_data_mem_wr_enb       = wr;
        i_data_mem_rd_enb       = rd;
        i_is_branch_instruction = br;
        i_alu_zero              = zero;
        i_alu_result            = alu;
        i_branch_addr           = baddr;
        i_rf_rt_data            = rt;
        i_rf_wr_enb             = rfwe;
        i_rf_wr_data_src        = src;
        i_rf_wr_addr            = waddr;
        i_dbg_mem_addr          = dbg;
        #1;
        check("pc_src", 32'(o_pc_src), 32'(br && zero));
        check("branch_addr", o_branch_addr, baddr);
`ifdef MEM_STAGE_DEBUG_PORT_EN
        if (m_valid[dbg]) check("dbg_data", o_dbg_mem_data, m_mem[dbg]);
`else
        check("dbg_data", o_dbg_mem_data, '0);
`endif
        @(posedge i_clock);
        idx    = int'(alu / 4) % DEPTH;
        mis    = (alu % 4 != 0) && (wr || rd);
        exp_rd = '0;
        if (rd && !mis) exp_rd = m_mem[idx];
        if (wr && !mis) begin
            m_mem[idx]   = rt;
            m_valid[idx] = 1'b1;
        end
        if (mis) m_mis = 1'b1;
        #1;
        if (!(rd && !mis) || m_valid[idx] || wr) begin
            if (!(rd && !mis) || m_valid[idx]) check("rd_data", o_mem_rd_data_ltchd, exp_rd);
        end
        check("alu_ltchd", o_alu_result_ltchd, alu);
        check("we_ltchd", 32'(o_rf_wr_enb_ltchd), 32'(rfwe));
        check("src_ltchd", 32'(o_rf_wr_data_src_ltchd), 32'(src));
        check("waddr_ltchd", 32'(o_rf_wr_addr_ltchd), 32'(waddr));
        check("misalign", 32'(o_mem_misalign), 32'(m_mis));
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 6'd0);
    endtask

    initial begin
        logic [NB_DATA-1:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_mem[i]   = '0;
        end
        m_mis = 1'b0;
        i_reset = 1'b1;
        i_data_mem_wr_enb = 0; i_data_mem_rd_enb = 0; i_is_branch_instruction = 0;
        i_alu_result = '0; i_alu_zero = 0; i_branch_addr = '0; i_rf_rt_data = '0;
        i_rf_wr_enb = 0; i_rf_wr_data_src = 0; i_rf_wr_addr = '0; i_dbg_mem_addr = '0;
        #1;
        check_reset_state("reset_initial");
        @(posedge i_clock); #1;
        check_reset_state("reset_held");
        i_reset = 1'b0;

        // Fill memory so every later read has a defined expectation.
        for (int i = 0; i < DEPTH; i++)
            step(1, 0, 0, 0, 32'(i * 4), 32'h0, $urandom, 0, 0, 5'd0, 6'(i));

        // Store then load 0x8.
        step(1, 0, 0, 0, 32'h8, 32'h0, 32'hDEADBEEF, 0, 0, 5'd0, 6'd2);
        step(0, 1, 0, 0, 32'h8, 32'h0, 32'h0, 1, 1, 5'd9, 6'd2);
        check("dir_load_8", o_mem_rd_data_ltchd, 32'hDEADBEEF);
        check("dir_alu_8", o_alu_result_ltchd, 32'h8);

        // Read-before-write on the same word.
        step(1, 0, 0, 0, 32'h4, 32'h0, 32'h11, 0, 0, 5'd0, 6'd1);
        step(1, 1, 0, 0, 32'h4, 32'h0, 32'h22, 0, 0, 5'd0, 6'd1);
        check("dir_rbw_old", o_mem_rd_data_ltchd, 32'h11);
        step(0, 1, 0, 0, 32'h4, 32'h0, 32'h0, 0, 0, 5'd0, 6'd1);
        check("dir_rbw_new", o_mem_rd_data_ltchd, 32'h22);

        // Branch resolution.
        step(0, 0, 1, 1, 32'h0, 32'h40, 32'h0, 0, 0, 5'd0, 6'd0);
        step(0, 0, 1, 0, 32'h0, 32'h40, 32'h0, 0, 0, 5'd0, 6'd0);

        // Address wrap: 0x100 lands on word 0.
        step(1, 0, 0, 0, 32'h100, 32'h0, 32'h55, 0, 0, 5'd0, 6'd0);
        step(0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 6'd0);
        check("dir_wrap", o_mem_rd_data_ltchd, 32'h55);

        // Misaligned store sets the sticky flag and leaves 0x4 unchanged.
        step(1, 0, 0, 0, 32'h6, 32'h0, 32'hBAD0BAD0, 0, 0, 5'd0, 6'd1);
        check("dir_mis_set", 32'(o_mem_misalign), 1);
        step(0, 1, 0, 0, 32'h4, 32'h0, 32'h0, 0, 0, 5'd0, 6'd1);
        check("dir_mis_4", o_mem_rd_data_ltchd, 32'h22);
        check("dir_mis_sticky", 32'(o_mem_misalign), 1);

        // Reset pulse mid-run while a store is presented: the outputs clear at
        // once and the store is dropped.
        i_data_mem_wr_enb = 1; i_data_mem_rd_enb = 0;
        i_alu_result = 32'h8; i_rf_rt_data = 32'hCAFEF00D;
        i_rf_wr_enb = 1; i_rf_wr_addr = 5'd7;
        i_reset = 1'b1;
        #1;
        check_reset_state("reset_mid");
        @(posedge i_clock); #1;
        check_reset_state("reset_mid_edge");
        i_reset = 1'b0;
        m_mis = 1'b0;
        step(0, 1, 0, 0, 32'h8, 32'h0, 32'h0, 0, 0, 5'd0, 6'd2);
        check("dir_reset_drop", o_mem_rd_data_ltchd, 32'hDEADBEEF);

        // Randomized traffic, mostly aligned.
        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, $urandom,
                 $urandom, 1'($urandom), 1'($urandom), 5'($urandom), 6'($urandom));
        end
        nop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
